// File: rtl/nf10_gmac_pkg.sv
// rtl/nf10_gmac_pkg.sv - shared states, byte constants and CRC32 helpers for the GMAC tx path
package nf10_gmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - one-byte step of the reflected Ethernet CRC32 (LSB of data first)
module crc32_d8
  import nf10_gmac_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] next_crc_o
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  always_comb begin
    next_crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (next_crc_o[0] ^ data_i[i]) begin
        next_crc_o = (next_crc_o >> 1) ^ POLY_R;
      end else begin
        next_crc_o = next_crc_o >> 1;
      end
    end
  end

endmodule

// File: rtl/gmac_tx_framer.sv
// rtl/gmac_tx_framer.sv - 1G MAC GMII transmit framer; NF10_GMAC_TX_PAD_EN enables padding to MIN_FRAME
module gmac_tx_framer
  import nf10_gmac_pkg::*;
#(
  parameter int MAX_FRAME      = 1514,
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES      = 12
`ifdef NF10_GMAC_TX_PAD_EN
  ,
  parameter int MIN_FRAME      = 60
`endif
) (
  input  logic       clk125,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_ack,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er
);

  localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME);
  localparam logic [10:0] CNT_SAT  = 11'h7FF;
  localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_BYTES - 1);
  localparam logic [4:0]  IFG_LAST = 5'(IFG_BYTES - 1);
  localparam logic [4:0]  FCS_LAST = 5'd3;
`ifdef NF10_GMAC_TX_PAD_EN
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
`endif

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [31:0] crc_q, crc_d, crc_next, fcs;
  logic [7:0]  data_q, data_d, crc_byte;
  logic        oversize_q, oversize_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;

  crc32_d8 u_crc (
    .crc_i      (crc_q),
    .data_i     (crc_byte),
    .next_crc_o (crc_next)
  );

  assign byte_cnt_inc = (byte_cnt_q == CNT_SAT) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign fcs          = ~crc_q;
  assign tx_ack       = (state_q == ST_SFD);
  assign gmii_txd     = txd_q;
  assign gmii_tx_en   = tx_en_q;
  assign gmii_tx_er   = tx_er_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    data_d     = data_q;
    oversize_d = oversize_q;
    crc_byte   = data_q;
    txd_d      = 8'h00;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_data_valid) begin
          state_d = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = PREAMBLE_BYTE;
        if (!tx_data_valid) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end else if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_SFD: begin
        tx_en_d    = 1'b1;
        txd_d      = SFD_BYTE;
        data_d     = tx_data;
        crc_d      = CRC_INIT;
        byte_cnt_d = '0;
        oversize_d = 1'b0;
        state_d    = ST_DATA;
      end

      ST_DATA: begin
        tx_en_d    = 1'b1;
        txd_d      = data_q;
        crc_d      = crc_next;
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_q >= MAX_CNT) begin
          tx_er_d    = 1'b1;
          oversize_d = 1'b1;
        end
        if (tx_data_valid) begin
          data_d = tx_data;
        end else begin
          cnt_d = '0;
`ifdef NF10_GMAC_TX_PAD_EN
          state_d = (byte_cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
`else
          state_d = ST_FCS;
`endif
        end
      end

`ifdef NF10_GMAC_TX_PAD_EN
      ST_PAD: begin
        tx_en_d    = 1'b1;
        txd_d      = 8'h00;
        crc_byte   = 8'h00;
        crc_d      = crc_next;
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_inc == MIN_CNT) begin
          state_d = ST_FCS;
        end
      end
`endif

      ST_FCS: begin
        tx_en_d = 1'b1;
        tx_er_d = oversize_q;
        txd_d   = fcs[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == FCS_LAST) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d = '0;
          // A pending frame skips IDLE so back-to-back frames see exactly IFG_BYTES idle cycles.
          state_d = tx_data_valid ? ST_PREAMBLE : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      crc_q      <= CRC_INIT;
      data_q     <= '0;
      oversize_q <= 1'b0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      data_q     <= data_d;
      oversize_q <= oversize_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
    end
  end

endmodule

// File: tb/tb_gmac_tx_framer.sv
// tb/tb_gmac_tx_framer.sv - self-checking bench for gmac_tx_framer against a frame-level reference model
module tb_gmac_tx_framer;
  import nf10_gmac_pkg::*;

  localparam int MAXF = 1514;
  localparam int MINF = 60;
  localparam int IFG  = 12;
`ifdef NF10_GMAC_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       clk125 = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_ack;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;

  always #4 clk125 = ~clk125;

  gmac_tx_framer dut (
    .clk125        (clk125),
    .reset_n       (reset_n),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_ack        (tx_ack),
    .gmii_txd      (gmii_txd),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_tx_er    (gmii_tx_er)
  );

  typedef struct {
    logic       en;
    logic       er;
    logic       ack;
    logic [7:0] d;
  } cyc_t;

  typedef struct {
    int len;
    int pat;
    int en_cyc;
    int er_cyc;
  } vec_t;

  cyc_t       exp_q[$];
  logic [7:0] cap[$];
  logic [7:0] pay[2][0:1599];
  int         flen[2];
  int         checks = 0;
  int         failures = 0;
  int         en_cnt, er_cnt, ack_cnt;
  vec_t       vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk125);
    #1;
  endtask

  // MSB-first (non-reflected) CRC fed with each byte LSB first, as bits leave on the wire.
  function automatic logic [31:0] crc_wire(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic void fill(input int f, input int len, input int pat);
    flen[f] = len;
    for (int i = 0; i < len; i++) begin
      case (pat)
        0:       pay[f][i] = 8'h00;
        1:       pay[f][i] = 8'(i);
        default: pay[f][i] = 8'($urandom);
      endcase
    end
  endfunction

  function automatic void push_frame(input int f);
    logic [31:0] c;
    logic [31:0] fcs;
    logic        over;
    int          n;
    n    = flen[f];
    c    = 32'hFFFFFFFF;
    over = 1'b0;
    for (int i = 0; i < 7; i++) exp_q.push_back('{1'b1, 1'b0, (i == 6), PREAMBLE_BYTE});
    exp_q.push_back('{1'b1, 1'b0, 1'b0, SFD_BYTE});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b1, (i >= MAXF), 1'b0, pay[f][i]});
      if (i >= MAXF) over = 1'b1;
      c = crc_wire(c, pay[f][i]);
    end
    if (PAD_EN) begin
      for (int i = n; i < MINF; i++) begin
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 8'h00});
        c = crc_wire(c, 8'h00);
      end
    end
    for (int i = 0; i < 32; i++) fcs[i] = ~c[31-i];
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, over, 1'b0, fcs[8*i +: 8]});
    for (int i = 0; i < IFG; i++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 8'h00});
  endfunction

  task automatic run(input string tag, input int nfr);
    int    phase, f, k, first;
    logic  prev_en;
    string det;
    exp_q.delete();
    cap.delete();
    en_cnt = 0; er_cnt = 0; ack_cnt = 0;
    tx_data_valid = 1'b0;
    repeat (3) step();
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 8'h00});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 8'h00});
    for (int i = 0; i < nfr; i++) push_frame(i);
    phase = 0; f = 0; k = 0; first = -1; prev_en = 1'b0; det = "";
    for (int c = 0; c < exp_q.size(); c++) begin
      cyc_t e;
      e = exp_q[c];
      if ((gmii_tx_en !== e.en) || (gmii_tx_er !== e.er) || (tx_ack !== e.ack) ||
          (e.en && (gmii_txd !== e.d))) begin
        if (first < 0) begin
          first = c;
          det = $sformatf("cyc%0d txd/en/er/ack=%02h/%0b/%0b/%0b want %02h/%0b/%0b/%0b",
                          c, gmii_txd, gmii_tx_en, gmii_tx_er, tx_ack, e.d, e.en, e.er, e.ack);
        end
      end
      if (gmii_tx_en === 1'b1) begin
        en_cnt++;
        cap.push_back(gmii_txd);
      end
      if (gmii_tx_er === 1'b1) er_cnt++;
      if (tx_ack === 1'b1) ack_cnt++;
      case (phase)
        0: begin
          tx_data_valid = 1'b1;
          tx_data       = pay[f][0];
          if (tx_ack === 1'b1) begin
            phase = 1;
            k     = 1;
          end
        end
        1: begin
          if (k < flen[f]) begin
            tx_data_valid = 1'b1;
            tx_data       = pay[f][k];
            k++;
          end else begin
            tx_data_valid = 1'b0;
            tx_data       = 8'($urandom);
            phase         = 2;
          end
        end
        default: begin
          if ((f + 1 < nfr) && prev_en && (gmii_tx_en === 1'b0)) begin
            f++;
            phase         = 0;
            tx_data_valid = 1'b1;
            tx_data       = pay[f][0];
          end
        end
      endcase
      prev_en = gmii_tx_en;
      step();
    end
    chk({tag, " trace ", det}, 32'(first), 32'hFFFFFFFF);
    chk({tag, " ack pulses"}, 32'(ack_cnt), 32'(nfr));
  endtask

  task automatic chk_residue(input string tag);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < cap.size(); i++) c = crc_wire(c, cap[i]);
    chk({tag, " crc residue"}, c, CRC_RESIDUE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit actual=expired required=done");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int ack_n, sfd_n, late_n, pre_seen;

    vecs[0] = '{64,   1, 76,                     0};
    vecs[1] = '{20,   1, (PAD_EN ? 72 : 32),     0};
    vecs[2] = '{60,   0, 72,                     0};
    vecs[3] = '{59,   2, (PAD_EN ? 72 : 71),     0};
    vecs[4] = '{61,   2, 73,                     0};
    vecs[5] = '{1,    1, (PAD_EN ? 72 : 13),     0};
    vecs[6] = '{1514, 2, 1526,                   0};
    vecs[7] = '{1515, 1, 1527,                   5};
    vecs[8] = '{1520, 2, 1532,                  10};

    repeat (3) @(posedge clk125);
    #1;
    chk("reset tx_en", 32'(gmii_tx_en), 0);
    chk("reset tx_er", 32'(gmii_tx_er), 0);
    chk("reset txd", 32'(gmii_txd), 0);
    chk("reset tx_ack", 32'(tx_ack), 0);
    reset_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      string tag;
      tag = $sformatf("vec%0d len%0d", v, vecs[v].len);
      fill(0, vecs[v].len, vecs[v].pat);
      run(tag, 1);
      chk({tag, " tx_en cycles"}, 32'(en_cnt), 32'(vecs[v].en_cyc));
      chk({tag, " tx_er cycles"}, 32'(er_cnt), 32'(vecs[v].er_cyc));
      chk_residue(tag);
    end

    for (int r = 0; r < 6; r++) begin
      string tag;
      tag = $sformatf("rand%0d", r);
      fill(0, int'($urandom_range(1, 150)), 2);
      run(tag, 1);
      chk_residue(tag);
    end

    fill(0, 30, 2);
    fill(1, 70, 2);
    run("back-to-back", 2);

    tx_data_valid = 1'b0;
    repeat (3) step();
    ack_n = 0; sfd_n = 0; late_n = 0; pre_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (tx_ack === 1'b1) ack_n++;
      if (gmii_tx_en === 1'b1 && gmii_txd === SFD_BYTE) sfd_n++;
      if (c >= 8 && gmii_tx_en !== 1'b0) late_n++;
      if (c == 2 && gmii_tx_en === 1'b1 && gmii_txd === PREAMBLE_BYTE) pre_seen = 1;
      tx_data_valid = (c < 4);
      tx_data       = 8'($urandom);
      step();
    end
    chk("abort preamble started", 32'(pre_seen), 1);
    chk("abort tx_ack pulses", 32'(ack_n), 0);
    chk("abort sfd bytes", 32'(sfd_n), 0);
    chk("abort tx_en after drop", 32'(late_n), 0);
    fill(0, 25, 1);
    run("after abort", 1);
    chk_residue("after abort");

    tx_data_valid = 1'b0;
    repeat (3) step();
    for (int c = 0; c < 20; c++) begin
      tx_data_valid = 1'b1;
      tx_data       = 8'($urandom);
      step();
    end
    chk("mid-data tx_en before reset", 32'(gmii_tx_en), 1);
    reset_n = 1'b0;
    #1;
    chk("mid-data reset tx_en", 32'(gmii_tx_en), 0);
    chk("mid-data reset tx_er", 32'(gmii_tx_er), 0);
    chk("mid-data reset txd", 32'(gmii_txd), 0);
    chk("mid-data reset tx_ack", 32'(tx_ack), 0);
    tx_data_valid = 1'b0;
    en_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (c == 1) reset_n = 1'b1;
      if (gmii_tx_en !== 1'b0) en_cnt++;
    end
    chk("no fcs after reset", 32'(en_cnt), 0);
    fill(0, 64, 2);
    run("after reset", 1);
    chk_residue("after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
